data_sram_responder: RTL and testbench

- Memory-side responder for the pipeline core's data SRAM port. It is the other end of the core's memwrite/aluout/writedata/sel/readdata/d_stall interface.
- Accepts one load or store at a time and services it from an internal word array after a configurable latency.
- Drives d_stall so the core's hazard unit freezes the pipeline until the access completes.
- Holds read data stable while the core remains globally stalled (longest_stall).

---
 rtl/data_sram_responder_if.sv | 21 ++
 rtl/data_sram_responder.sv | 105 ++++++++++
 tb/tb_data_sram_responder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/data_sram_responder_if.sv
// Data-SRAM port between the pipeline core (master) and its memory responder (slave).
// Request fields must be held stable by the core while d_stall is high.
interface data_sram_responder_if;
    logic        req_en;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        longest_stall;
    logic [31:0] rdata;
    logic        d_stall;

    modport master (
        output req_en, req_wen, req_addr, req_wdata, longest_stall,
        input  rdata, d_stall
    );

    modport slave (
        input  req_en, req_wen, req_addr, req_wdata, longest_stall,
        output rdata, d_stall
    );
endinterface

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: one access at a time, d_stall high LATENCY+1 cycles, data valid in first DONE cycle.
// Holds rdata while longest_stall freezes the core; DSRAM_RESP_RAND_LAT_EN randomises latency in 1..LATENCY.
module data_sram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic resetn,
    data_sram_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic [3:0]          cnt_load;
    logic [ADDR_W-1:0]   idx;
    logic [3:0]          wen;
    logic [31:0]         wdata;
    logic [31:0]         rdata_q;
    logic [31:0]         mem [2**ADDR_W];
    logic                accept;
    logic                fire;
    logic                unused_addr_bits;

    assign accept = (state == IDLE) && bus.req_en;
    assign fire   = (state == BUSY) && (cnt == 4'd0);
    assign bus.rdata = rdata_q;
    assign unused_addr_bits = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};

`ifdef DSRAM_RESP_RAND_LAT_EN
    logic [7:0] lfsr;

    // x^8+x^6+x^5+x^4+1, stepped once per accepted request
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            lfsr <= 8'hA5;
        else if (accept)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign cnt_load = 4'(lfsr % 8'(LATENCY));
`else
    assign cnt_load = 4'(LATENCY - 1);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.d_stall = 1'b0;
        case (state)
            IDLE: begin
                bus.d_stall = bus.req_en;
                if (bus.req_en)
                    state_nxt = BUSY;
            end
            BUSY: begin
                bus.d_stall = 1'b1;
                if (cnt == 4'd0)
                    state_nxt = DONE;
            end
            DONE: begin
                // Stay put while the core is frozen so the access is not re-serviced
                if (!bus.longest_stall || !bus.req_en)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= 4'd0;
            idx     <= '0;
            wen     <= 4'd0;
            wdata   <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                cnt   <= cnt_load;
                idx   <= bus.req_addr[ADDR_W+1:2];
                wen   <= bus.req_wen;
                wdata <= bus.req_wdata;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (fire && wen == 4'd0)
                rdata_q <= mem[idx];
        end
    end

    // Contents survive reset; fire is gated by state, which reset forces to IDLE
    always_ff @(posedge clk) begin
        if (fire) begin
            for (int i = 0; i < 4; i++)
                if (wen[i])
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder (default ADDR_W=10, LATENCY=2).
module tb_data_sram_responder;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    data_sram_responder_if bus();

    data_sram_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        int          exp_stalls;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete access; rdata checked for stability over 'hold' extra frozen DONE cycles
    task automatic access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, output logic [31:0] data, output int stalls);
        @(negedge clk);
        bus.req_en        = 1'b1;
        bus.req_wen       = wen;
        bus.req_addr      = addr;
        bus.req_wdata     = wdata;
        bus.longest_stall = 1'b1;
        stalls = 0;
        #1;
        while (bus.d_stall && stalls < 50) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        data = bus.rdata;
        for (int i = 0; i < hold; i++) begin
            bus.req_wdata = ~wdata;
            @(negedge clk);
            #1;
            chk("hold_dstall", {31'b0, bus.d_stall}, 32'd0);
            chk("hold_rdata", bus.rdata, data);
        end
        bus.req_en        = 1'b0;
        bus.longest_stall = 1'b0;
        @(negedge clk);
        #1;
        chk("post_idle_dstall", {31'b0, bus.d_stall}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] data;
        int          stalls;

        checks = 0;
        errors = 0;
        vecs[0]  = '{4'hF, 32'h0000_0010, 32'hDEADBEEF, 0, 3, 32'h0000_0000};
        vecs[1]  = '{4'h0, 32'h0000_0010, 32'h0,        0, 3, 32'hDEADBEEF};
        vecs[2]  = '{4'hF, 32'h0000_0010, 32'h11223344, 0, 3, 32'hDEADBEEF};
        vecs[3]  = '{4'h4, 32'h0000_0012, 32'h00AB0000, 0, 3, 32'hDEADBEEF};
        vecs[4]  = '{4'h0, 32'h0000_0010, 32'h0,        0, 3, 32'h11AB3344};
        vecs[5]  = '{4'hF, 32'h0000_0020, 32'h55667788, 4, 3, 32'h11AB3344};
        vecs[6]  = '{4'h0, 32'h0000_0020, 32'h0,        4, 3, 32'h55667788};
        vecs[7]  = '{4'hF, 32'h0000_1000, 32'hCAFEF00D, 0, 3, 32'h55667788};
        vecs[8]  = '{4'h0, 32'h0000_0000, 32'h0,        0, 3, 32'hCAFEF00D};
        vecs[9]  = '{4'h0, 32'h0000_0013, 32'h0,        0, 3, 32'h11AB3344};
        vecs[10] = '{4'h9, 32'h0000_0010, 32'hAA0000BB, 0, 3, 32'h11AB3344};
        vecs[11] = '{4'h0, 32'h0000_0010, 32'h0,        0, 3, 32'hAAAB33BB};

        resetn            = 1'b0;
        bus.req_en        = 1'b0;
        bus.req_wen       = 4'h0;
        bus.req_addr      = 32'h0;
        bus.req_wdata     = 32'h0;
        bus.longest_stall = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d_dstall", i), {31'b0, bus.d_stall}, 32'd0);
            chk($sformatf("idle%0d_rdata", i), bus.rdata, 32'h0);
        end

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].hold, data, stalls);
            chk($sformatf("vec%0d_stalls", i), 32'(stalls), 32'(vecs[i].exp_stalls));
            chk($sformatf("vec%0d_rdata", i), data, vecs[i].exp_rdata);
        end

        // Held req_en across DONE->IDLE is a fresh request
        @(negedge clk);
        bus.req_en = 1'b1; bus.req_wen = 4'h0; bus.req_addr = 32'h20; bus.longest_stall = 1'b1;
        stalls = 0;
        #1;
        while (bus.d_stall && stalls < 50) begin stalls++; @(negedge clk); #1; end
        chk("b2b_first_stalls", 32'(stalls), 32'd3);
        chk("b2b_first_rdata", bus.rdata, 32'h55667788);
        bus.req_addr = 32'h10;
        bus.longest_stall = 1'b0;
        @(negedge clk);
        #1;
        chk("b2b_second_accepted", {31'b0, bus.d_stall}, 32'd1);
        bus.longest_stall = 1'b1;
        stalls = 0;
        while (bus.d_stall && stalls < 50) begin stalls++; @(negedge clk); #1; end
        chk("b2b_second_stalls", 32'(stalls), 32'd3);
        chk("b2b_second_rdata", bus.rdata, 32'hAAAB33BB);
        bus.req_en = 1'b0; bus.longest_stall = 1'b0;
        @(negedge clk);

        // req_en dropped mid-BUSY with garbage on the bus: store still commits latched values
        bus.req_en = 1'b1; bus.req_wen = 4'hF; bus.req_addr = 32'h30; bus.req_wdata = 32'h12345678;
        bus.longest_stall = 1'b1;
        @(negedge clk);
        bus.req_en = 1'b0; bus.req_addr = 32'h34; bus.req_wdata = 32'hFFFF_FFFF;
        #1;
        chk("flush_busy_dstall", {31'b0, bus.d_stall}, 32'd1);
        stalls = 1;
        while (bus.d_stall && stalls < 50) begin stalls++; @(negedge clk); #1; end
        chk("flush_stalls", 32'(stalls), 32'd3);
        bus.longest_stall = 1'b0;
        @(negedge clk);
        #1;
        chk("flush_idle_dstall", {31'b0, bus.d_stall}, 32'd0);
        access(4'h0, 32'h30, 32'h0, 0, data, stalls);
        chk("flush_store_committed", data, 32'h12345678);
        access(4'h0, 32'h34, 32'h0, 0, data, stalls);
        chk("flush_neighbour_untouched", data === 32'hFFFF_FFFF ? 32'd1 : 32'd0, 32'd0);

        // Reset in the final BUSY cycle of a store abandons the write
        access(4'hF, 32'h40, 32'h11111111, 0, data, stalls);
        @(negedge clk);
        bus.req_en = 1'b1; bus.req_wen = 4'hF; bus.req_addr = 32'h40; bus.req_wdata = 32'h22222222;
        bus.longest_stall = 1'b1;
        #1;
        chk("rst_req_dstall", {31'b0, bus.d_stall}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0; bus.req_en = 1'b0; bus.longest_stall = 1'b0;
        #1;
        chk("rst_dstall", {31'b0, bus.d_stall}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        access(4'h0, 32'h40, 32'h0, 0, data, stalls);
        chk("rst_no_write", data, 32'h11111111);
        chk("rst_after_stalls", 32'(stalls), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
